// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared types and helpers for the decode hazard unit
package hazard_scoreboard_pkg;

    localparam int NUM_ARCH_REGS = 32;

    typedef enum logic [2:0] {
        NONE        = 3'd0,
        FWD_NOT_RDY = 3'd1,
        RAW_LL      = 3'd2,
        WAW_LL      = 3'd3,
        LL_FULL     = 3'd4
    } stall_cause_t;

    // True when a valid producer targets the given register index
    function automatic logic reg_hit(input logic valid, input logic [4:0] idx, input logic [4:0] rs);
        return valid && (idx == rs);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd_mux.sv
// rtl/hazard_scoreboard_fwd_mux.sv - one read port's operand select and not-ready flag
module hazard_scoreboard_fwd_mux #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 3
) (
    input  logic [4:0]              rs,
    input  logic                    used,
    input  logic [XLEN-1:0]         rf_v,
    input  logic                    ll_wb_valid,
    input  logic [4:0]              ll_wb_rd,
    input  logic [XLEN-1:0]         ll_wb_v,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD-1:0]      fwd_rd_we,
    input  logic [NUM_FWD*5-1:0]    fwd_rd_s,
    input  logic [NUM_FWD*XLEN-1:0] fwd_rd_v,
    input  logic [NUM_FWD-1:0]      fwd_data_rdy,
    output logic [XLEN-1:0]         v,
    output logic                    not_rdy
);
    import hazard_scoreboard_pkg::*;

    logic hit;

    // First match wins: LL writeback, then youngest-to-oldest pipeline stage, else regfile
    always_comb begin
        v       = rf_v;
        not_rdy = 1'b0;
        hit     = 1'b0;
        if (used && rs != 5'd0) begin
            if (reg_hit(ll_wb_valid, ll_wb_rd, rs)) begin
                v   = ll_wb_v;
                hit = 1'b1;
            end
            for (int i = 0; i < NUM_FWD; i++) begin
                if (!hit && reg_hit(fwd_valid[i] && fwd_rd_we[i], fwd_rd_s[i*5 +: 5], rs)) begin
                    hit     = 1'b1;
                    v       = fwd_rd_v[i*XLEN +: XLEN];
                    not_rdy = !fwd_data_rdy[i];
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - decode-stage forwarding, hazard detection and LL scoreboard
module hazard_scoreboard #(
    parameter int XLEN            = 32,
    parameter int NUM_RD_PORTS    = 2,
    parameter int NUM_FWD         = 3,
    parameter int MAX_LL_INFLIGHT = 2,
    parameter int CNT_W           = 32,
    localparam int IW             = $clog2(MAX_LL_INFLIGHT + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         id_valid_i,
    input  logic [NUM_RD_PORTS*5-1:0]    id_rs_s_i,
    input  logic [NUM_RD_PORTS-1:0]      id_rs_used_i,
    input  logic [NUM_RD_PORTS*XLEN-1:0] id_rf_v_i,
    input  logic [4:0]                   id_rd_s_i,
    input  logic                         id_rd_we_i,
    input  logic                         id_is_ll_i,
    input  logic                         ex_ready_i,
    input  logic [NUM_FWD-1:0]           fwd_valid_i,
    input  logic [NUM_FWD-1:0]           fwd_rd_we_i,
    input  logic [NUM_FWD*5-1:0]         fwd_rd_s_i,
    input  logic [NUM_FWD*XLEN-1:0]      fwd_rd_v_i,
    input  logic [NUM_FWD-1:0]           fwd_data_rdy_i,
    input  logic                         ll_wb_valid_i,
    input  logic [4:0]                   ll_wb_rd_s_i,
    input  logic [XLEN-1:0]              ll_wb_v_i,
    output logic [NUM_RD_PORTS*XLEN-1:0] rs_v_o,
    output logic                         stall_o,
    output logic [2:0]                   stall_cause_o,
    output logic                         issue_o,
    output logic [31:0]                  ll_pending_o,
    output logic [IW-1:0]                ll_inflight_o,
    output logic [CNT_W-1:0]             stall_cycles_o
);
    import hazard_scoreboard_pkg::*;

    localparam logic [IW-1:0] MAX_CNT = IW'(MAX_LL_INFLIGHT);

    logic [NUM_ARCH_REGS-1:0] pend;
    logic [IW-1:0]            inflight;
    logic [CNT_W-1:0]         stall_cycles;
    logic [NUM_RD_PORTS-1:0]  not_rdy;
    logic                     raw_hit;
    logic                     waw_hit;
    logic                     full_hit;
    logic                     ll_issue;
    stall_cause_t             cause;

    genvar p;
    generate
        for (p = 0; p < NUM_RD_PORTS; p++) begin : g_port
            hazard_scoreboard_fwd_mux #(
                .XLEN    (XLEN),
                .NUM_FWD (NUM_FWD)
            ) u_fwd_mux (
                .rs           (id_rs_s_i[p*5 +: 5]),
                .used         (id_rs_used_i[p]),
                .rf_v         (id_rf_v_i[p*XLEN +: XLEN]),
                .ll_wb_valid  (ll_wb_valid_i),
                .ll_wb_rd     (ll_wb_rd_s_i),
                .ll_wb_v      (ll_wb_v_i),
                .fwd_valid    (fwd_valid_i),
                .fwd_rd_we    (fwd_rd_we_i),
                .fwd_rd_s     (fwd_rd_s_i),
                .fwd_rd_v     (fwd_rd_v_i),
                .fwd_data_rdy (fwd_data_rdy_i),
                .v            (rs_v_o[p*XLEN +: XLEN]),
                .not_rdy      (not_rdy[p])
            );
        end
    endgenerate

    // A used source still owned by an LL op stalls unless that op writes back this cycle
    always_comb begin
        raw_hit = 1'b0;
        for (int i = 0; i < NUM_RD_PORTS; i++) begin
            if (id_rs_used_i[i] && id_rs_s_i[i*5 +: 5] != 5'd0 && pend[id_rs_s_i[i*5 +: 5]]
                && !reg_hit(ll_wb_valid_i, ll_wb_rd_s_i, id_rs_s_i[i*5 +: 5])) begin
                raw_hit = 1'b1;
            end
        end
    end

    assign waw_hit  = id_rd_we_i && id_rd_s_i != 5'd0 && pend[id_rd_s_i]
                      && !reg_hit(ll_wb_valid_i, ll_wb_rd_s_i, id_rd_s_i);
    assign full_hit = id_is_ll_i && inflight == MAX_CNT && !ll_wb_valid_i;

    // Report the highest-priority stall reason
    always_comb begin
        cause = NONE;
        if (|not_rdy)      cause = FWD_NOT_RDY;
        else if (raw_hit)  cause = RAW_LL;
        else if (waw_hit)  cause = WAW_LL;
        else if (full_hit) cause = LL_FULL;
    end

    assign stall_cause_o  = cause;
    assign stall_o        = id_valid_i && !flush_i && cause != NONE;
    assign issue_o        = id_valid_i && !flush_i && !stall_o && ex_ready_i;
    assign ll_issue       = issue_o && id_is_ll_i;
    assign ll_pending_o   = pend;
    assign ll_inflight_o  = inflight;
    assign stall_cycles_o = stall_cycles;

    // Scoreboard: writeback clears, LL issue sets; the set is applied last so it wins on a tie
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend     <= '0;
            inflight <= '0;
        end else begin
            if (ll_wb_valid_i) pend[ll_wb_rd_s_i] <= 1'b0;
            if (ll_issue && id_rd_we_i && id_rd_s_i != 5'd0) pend[id_rd_s_i] <= 1'b1;
            if (ll_issue && !ll_wb_valid_i)      inflight <= inflight + IW'(1);
            else if (!ll_issue && ll_wb_valid_i) inflight <= inflight - IW'(1);
        end
    end

    // Saturating count of cycles spent holding decode
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                              stall_cycles <= '0;
        else if (stall_o && stall_cycles != '1)   stall_cycles <= stall_cycles + CNT_W'(1);
    end

    // Writebacks to x0 come from LL ops without a tracked destination
    a_wb_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (ll_wb_valid_i && ll_wb_rd_s_i != 5'd0) |-> pend[ll_wb_rd_s_i]);
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ll_wb_valid_i |-> inflight != '0);
    a_no_overissue: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (ll_issue && !ll_wb_valid_i) |-> inflight != MAX_CNT);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int XLEN = 32;
    localparam int NP   = 2;
    localparam int NF   = 3;
    localparam int MAXL = 2;
    localparam int CW   = 32;
    localparam int IW   = $clog2(MAXL + 1);
    localparam logic [31:0] RF0 = 32'hAAAA_0000;
    localparam logic [31:0] RF1 = 32'hBBBB_0000;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               flush_i;
    logic               id_valid_i;
    logic [NP*5-1:0]    id_rs_s_i;
    logic [NP-1:0]      id_rs_used_i;
    logic [NP*XLEN-1:0] id_rf_v_i;
    logic [4:0]         id_rd_s_i;
    logic               id_rd_we_i;
    logic               id_is_ll_i;
    logic               ex_ready_i;
    logic [NF-1:0]      fwd_valid_i;
    logic [NF-1:0]      fwd_rd_we_i;
    logic [NF*5-1:0]    fwd_rd_s_i;
    logic [NF*XLEN-1:0] fwd_rd_v_i;
    logic [NF-1:0]      fwd_data_rdy_i;
    logic               ll_wb_valid_i;
    logic [4:0]         ll_wb_rd_s_i;
    logic [XLEN-1:0]    ll_wb_v_i;
    logic [NP*XLEN-1:0] rs_v_o;
    logic               stall_o;
    logic [2:0]         stall_cause_o;
    logic               issue_o;
    logic [31:0]        ll_pending_o;
    logic [IW-1:0]      ll_inflight_o;
    logic [CW-1:0]      stall_cycles_o;

    always #5 clk_i = ~clk_i;

    hazard_scoreboard #(
        .XLEN(XLEN), .NUM_RD_PORTS(NP), .NUM_FWD(NF), .MAX_LL_INFLIGHT(MAXL), .CNT_W(CW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .id_valid_i(id_valid_i),
        .id_rs_s_i(id_rs_s_i), .id_rs_used_i(id_rs_used_i), .id_rf_v_i(id_rf_v_i),
        .id_rd_s_i(id_rd_s_i), .id_rd_we_i(id_rd_we_i), .id_is_ll_i(id_is_ll_i),
        .ex_ready_i(ex_ready_i), .fwd_valid_i(fwd_valid_i), .fwd_rd_we_i(fwd_rd_we_i),
        .fwd_rd_s_i(fwd_rd_s_i), .fwd_rd_v_i(fwd_rd_v_i), .fwd_data_rdy_i(fwd_data_rdy_i),
        .ll_wb_valid_i(ll_wb_valid_i), .ll_wb_rd_s_i(ll_wb_rd_s_i), .ll_wb_v_i(ll_wb_v_i),
        .rs_v_o(rs_v_o), .stall_o(stall_o), .stall_cause_o(stall_cause_o), .issue_o(issue_o),
        .ll_pending_o(ll_pending_o), .ll_inflight_o(ll_inflight_o), .stall_cycles_o(stall_cycles_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model state: outstanding LL ops as a list of their destination (0 = untracked)
    logic [4:0]  ll_q[$];
    int          m_count;
    logic [31:0] m_v[NP];
    logic        m_stall;
    logic        m_issue;
    logic [2:0]  m_cause;

    function automatic bit is_pend(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (ll_q[i]) if (ll_q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] pend_map();
        logic [31:0] m;
        m = '0;
        foreach (ll_q[i]) if (ll_q[i] != 5'd0) m[ll_q[i]] = 1'b1;
        return m;
    endfunction

    task automatic model_eval();
        bit nr, raw, waw, full, hit;
        logic [4:0] rs;
        nr  = 1'b0;
        raw = 1'b0;
        for (int p = 0; p < NP; p++) begin
            rs     = id_rs_s_i[p*5 +: 5];
            m_v[p] = id_rf_v_i[p*XLEN +: XLEN];
            if (id_rs_used_i[p] && rs != 5'd0) begin
                hit = 1'b0;
                if (ll_wb_valid_i && ll_wb_rd_s_i == rs) begin
                    m_v[p] = ll_wb_v_i;
                    hit    = 1'b1;
                end
                for (int s = 0; s < NF; s++) begin
                    if (!hit && fwd_valid_i[s] && fwd_rd_we_i[s] && fwd_rd_s_i[s*5 +: 5] == rs) begin
                        hit    = 1'b1;
                        m_v[p] = fwd_rd_v_i[s*XLEN +: XLEN];
                        if (!fwd_data_rdy_i[s]) nr = 1'b1;
                    end
                end
                if (is_pend(rs) && !(ll_wb_valid_i && ll_wb_rd_s_i == rs)) raw = 1'b1;
            end
        end
        waw  = id_rd_we_i && id_rd_s_i != 5'd0 && is_pend(id_rd_s_i)
               && !(ll_wb_valid_i && ll_wb_rd_s_i == id_rd_s_i);
        full = id_is_ll_i && ll_q.size() == MAXL && !ll_wb_valid_i;
        m_cause = nr ? FWD_NOT_RDY : raw ? RAW_LL : waw ? WAW_LL : full ? LL_FULL : NONE;
        m_stall = id_valid_i && !flush_i && m_cause != NONE;
        m_issue = id_valid_i && !flush_i && !m_stall && ex_ready_i;
    endtask

    task automatic idle();
        flush_i = 0; id_valid_i = 0; id_rs_s_i = '0; id_rs_used_i = '0;
        id_rf_v_i = {RF1, RF0}; id_rd_s_i = '0; id_rd_we_i = 0; id_is_ll_i = 0; ex_ready_i = 1;
        fwd_valid_i = '0; fwd_rd_we_i = '0; fwd_rd_s_i = '0; fwd_data_rdy_i = '0;
        fwd_rd_v_i = {32'h22, 32'hDEAD, 32'h11};
        ll_wb_valid_i = 0; ll_wb_rd_s_i = '0; ll_wb_v_i = '0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 0;
        #1;
        rst_ni = 1;
        tick();
    endtask

    task automatic ll_issue(input logic [4:0] rd);
        id_valid_i = 1; id_is_ll_i = 1; id_rd_we_i = 1; id_rd_s_i = rd;
    endtask

    typedef struct {
        logic        ivalid, flush, exrdy;
        logic [1:0]  used;
        logic [4:0]  rs0, rs1;
        logic [2:0]  fval, fwe, frdy;
        logic [4:0]  frd0, frd1, frd2;
        logic [31:0] e0, e1;
        logic        estall, eissue;
        logic [2:0]  ecause;
    } vec_t;

    vec_t vt[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{1, 0, 1, 2'b01, 5'd5, 5'd0, 3'b001, 3'b001, 3'b000, 5'd5, 5'd0, 5'd0, 32'h11,   RF1,   1, 0, FWD_NOT_RDY};
        vt[1]  = '{1, 0, 1, 2'b01, 5'd5, 5'd0, 3'b010, 3'b010, 3'b010, 5'd0, 5'd5, 5'd0, 32'hDEAD, RF1,   0, 1, NONE};
        vt[2]  = '{1, 0, 1, 2'b10, 5'd0, 5'd3, 3'b101, 3'b101, 3'b101, 5'd3, 5'd0, 5'd3, RF0,      32'h11, 0, 1, NONE};
        vt[3]  = '{1, 0, 1, 2'b11, 5'd0, 5'd3, 3'b101, 3'b101, 3'b100, 5'd0, 5'd0, 5'd3, RF0,      32'h22, 0, 1, NONE};
        vt[4]  = '{1, 0, 1, 2'b00, 5'd5, 5'd0, 3'b001, 3'b001, 3'b000, 5'd5, 5'd0, 5'd0, RF0,      RF1,   0, 1, NONE};
        vt[5]  = '{1, 0, 1, 2'b01, 5'd5, 5'd0, 3'b011, 3'b010, 3'b010, 5'd5, 5'd5, 5'd0, 32'hDEAD, RF1,   0, 1, NONE};
        vt[6]  = '{1, 1, 1, 2'b01, 5'd5, 5'd0, 3'b001, 3'b001, 3'b000, 5'd5, 5'd0, 5'd0, 32'h11,   RF1,   0, 0, FWD_NOT_RDY};
        vt[7]  = '{1, 0, 0, 2'b01, 5'd5, 5'd0, 3'b010, 3'b010, 3'b010, 5'd0, 5'd5, 5'd0, 32'hDEAD, RF1,   0, 0, NONE};
        vt[8]  = '{1, 0, 1, 2'b01, 5'd5, 5'd0, 3'b011, 3'b011, 3'b001, 5'd5, 5'd5, 5'd0, 32'h11,   RF1,   0, 1, NONE};
        vt[9]  = '{0, 0, 1, 2'b01, 5'd5, 5'd0, 3'b001, 3'b001, 3'b000, 5'd5, 5'd0, 5'd0, 32'h11,   RF1,   0, 0, FWD_NOT_RDY};
        vt[10] = '{1, 0, 1, 2'b11, 5'd4, 5'd4, 3'b010, 3'b010, 3'b000, 5'd0, 5'd4, 5'd0, 32'hDEAD, 32'hDEAD, 1, 0, FWD_NOT_RDY};

        rst_ni = 0;
        idle();
        #3;
        check("reset pend", ll_pending_o, 32'h0);
        check("reset inflight", 32'(ll_inflight_o), 32'h0);
        check("reset stall_cycles", stall_cycles_o, 32'h0);
        check("reset stall", 32'(stall_o), 32'h0);
        @(negedge clk_i);
        rst_ni = 1;
        tick();

        // Table-driven forwarding vectors with an empty scoreboard
        foreach (vt[i]) begin
            idle();
            id_valid_i = vt[i].ivalid; flush_i = vt[i].flush; ex_ready_i = vt[i].exrdy;
            id_rs_used_i = vt[i].used; id_rs_s_i = {vt[i].rs1, vt[i].rs0};
            fwd_valid_i = vt[i].fval; fwd_rd_we_i = vt[i].fwe; fwd_data_rdy_i = vt[i].frdy;
            fwd_rd_s_i = {vt[i].frd2, vt[i].frd1, vt[i].frd0};
            #1;
            check($sformatf("vec%0d rs_v0", i), rs_v_o[31:0], vt[i].e0);
            check($sformatf("vec%0d rs_v1", i), rs_v_o[63:32], vt[i].e1);
            check($sformatf("vec%0d stall", i), 32'(stall_o), 32'(vt[i].estall));
            check($sformatf("vec%0d issue", i), 32'(issue_o), 32'(vt[i].eissue));
            check($sformatf("vec%0d cause", i), 32'(stall_cause_o), 32'(vt[i].ecause));
            tick();
        end

        // LL RAW hazard resolved by same-cycle writeback bypass
        idle();
        do_reset();
        ll_issue(5'd7);
        #1;
        check("llraw issue", 32'(issue_o), 32'h1);
        tick();
        idle();
        check("llraw pend set", ll_pending_o, 32'h80);
        check("llraw inflight", 32'(ll_inflight_o), 32'h1);
        id_valid_i = 1; id_rs_used_i = 2'b01; id_rs_s_i = {5'd0, 5'd7};
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("llraw stall c%0d", k), 32'(stall_o), 32'h1);
            check($sformatf("llraw cause c%0d", k), 32'(stall_cause_o), 32'(RAW_LL));
            check($sformatf("llraw noissue c%0d", k), 32'(issue_o), 32'h0);
            tick();
        end
        ll_wb_valid_i = 1; ll_wb_rd_s_i = 5'd7; ll_wb_v_i = 32'h1234;
        #1;
        check("llraw bypass value", rs_v_o[31:0], 32'h1234);
        check("llraw bypass issue", 32'(issue_o), 32'h1);
        tick();
        idle();
        check("llraw pend clear", ll_pending_o, 32'h0);
        check("llraw inflight 0", 32'(ll_inflight_o), 32'h0);
        check("llraw stall_cycles", stall_cycles_o, 32'd4);

        // Capacity limit and same-cycle writeback keeping the count level
        do_reset();
        ll_issue(5'd1); tick();
        ll_issue(5'd2); tick();
        check("cap inflight 2", 32'(ll_inflight_o), 32'h2);
        ll_issue(5'd3);
        #1;
        check("cap cause", 32'(stall_cause_o), 32'(LL_FULL));
        check("cap stall", 32'(stall_o), 32'h1);
        check("cap noissue", 32'(issue_o), 32'h0);
        tick();
        ll_wb_valid_i = 1; ll_wb_rd_s_i = 5'd1;
        #1;
        check("cap wb issue", 32'(issue_o), 32'h1);
        tick();
        idle();
        check("cap inflight held", 32'(ll_inflight_o), 32'h2);
        check("cap pend", ll_pending_o, 32'h0000_000C);

        // WAW stall, then clear and set of the same index in one cycle
        do_reset();
        ll_issue(5'd9); tick();
        idle();
        id_valid_i = 1; id_rd_we_i = 1; id_rd_s_i = 5'd9;
        #1;
        check("waw cause", 32'(stall_cause_o), 32'(WAW_LL));
        check("waw stall", 32'(stall_o), 32'h1);
        tick();
        idle();
        ll_issue(5'd9);
        ll_wb_valid_i = 1; ll_wb_rd_s_i = 5'd9;
        #1;
        check("waw setclr issue", 32'(issue_o), 32'h1);
        tick();
        idle();
        check("waw set wins", ll_pending_o, 32'h0000_0200);
        check("waw inflight", 32'(ll_inflight_o), 32'h1);

        // Stall counter, flush during stall, asynchronous reset mid-cycle
        do_reset();
        ll_issue(5'd9); tick();
        idle();
        check("cnt start", stall_cycles_o, 32'd0);
        id_valid_i = 1; id_rs_used_i = 2'b01; id_rs_s_i = {5'd0, 5'd9};
        repeat (10) tick();
        check("cnt ten", stall_cycles_o, 32'd10);
        flush_i = 1;
        #1;
        check("flush stall", 32'(stall_o), 32'h0);
        check("flush issue", 32'(issue_o), 32'h0);
        tick();
        check("flush cnt", stall_cycles_o, 32'd10);
        check("flush pend", ll_pending_o, 32'h0000_0200);
        check("flush inflight", 32'(ll_inflight_o), 32'h1);
        idle();
        #2;
        rst_ni = 0;
        #1;
        check("async pend", ll_pending_o, 32'h0);
        check("async inflight", 32'(ll_inflight_o), 32'h0);
        check("async cnt", stall_cycles_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1;
        tick();

        // Randomized traffic against the reference model
        ll_q.delete();
        m_count = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            int wb_idx;
            wb_idx         = -1;
            flush_i        = ($urandom_range(0, 9) == 0);
            id_valid_i     = ($urandom_range(0, 3) != 0);
            id_rs_s_i      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            id_rs_used_i   = 2'($urandom);
            id_rf_v_i      = {$urandom, $urandom};
            id_rd_s_i      = 5'($urandom_range(0, 7));
            id_rd_we_i     = ($urandom_range(0, 3) != 0);
            id_is_ll_i     = ($urandom_range(0, 2) == 0);
            ex_ready_i     = ($urandom_range(0, 3) != 0);
            fwd_valid_i    = 3'($urandom);
            fwd_rd_we_i    = 3'($urandom);
            fwd_rd_s_i     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            fwd_rd_v_i     = {$urandom, $urandom, $urandom};
            fwd_data_rdy_i = 3'($urandom) | 3'($urandom);
            ll_wb_v_i      = $urandom;
            ll_wb_rd_s_i   = 5'($urandom_range(0, 7));
            ll_wb_valid_i  = 0;
            if (ll_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                wb_idx        = int'($urandom_range(0, ll_q.size() - 1));
                ll_wb_valid_i = 1;
                ll_wb_rd_s_i  = ll_q[wb_idx];
            end
            #1;
            model_eval();
            check($sformatf("rnd%0d rs_v0", cyc), rs_v_o[31:0], m_v[0]);
            check($sformatf("rnd%0d rs_v1", cyc), rs_v_o[63:32], m_v[1]);
            check($sformatf("rnd%0d cause", cyc), 32'(stall_cause_o), 32'(m_cause));
            check($sformatf("rnd%0d stall", cyc), 32'(stall_o), 32'(m_stall));
            check($sformatf("rnd%0d issue", cyc), 32'(issue_o), 32'(m_issue));
            if (wb_idx >= 0) ll_q.delete(wb_idx);
            if (m_issue && id_is_ll_i) ll_q.push_back((id_rd_we_i && id_rd_s_i != 5'd0) ? id_rd_s_i : 5'd0);
            if (m_stall) m_count++;
            tick();
            check($sformatf("rnd%0d pend", cyc), ll_pending_o, pend_map());
            check($sformatf("rnd%0d inflight", cyc), 32'(ll_inflight_o), 32'(ll_q.size()));
            check($sformatf("rnd%0d stall_cycles", cyc), stall_cycles_o, 32'(m_count));
        end

        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
